// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default
// latencies and FSM state encoding.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5,
    MDU_NONE  = 3'd6
  } mdu_op_e;

  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_RUN  = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/mdu_arith.sv
// Combinational 2*WIDTH result generator for MULT/MULTU/DIV/DIVU.
// Division works on magnitudes so the 0x80000000 / -1 case falls out naturally.
module mdu_arith
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_rhi,
  output logic [WIDTH-1:0] o_rlo,
  output logic             o_div_by_zero
);

  logic [2*WIDTH-1:0] w_prod_s;
  logic [2*WIDTH-1:0] w_prod_u;
  logic               w_signed_div;
  logic               w_neg_a;
  logic               w_neg_b;
  logic               w_b_zero;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH-1:0]   w_div_b;
  logic [WIDTH-1:0]   w_q;
  logic [WIDTH-1:0]   w_r;

  always_comb begin
    w_prod_s     = {{WIDTH{i_a[WIDTH-1]}}, i_a} * {{WIDTH{i_b[WIDTH-1]}}, i_b};
    w_prod_u     = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};
    w_signed_div = (i_op == MDU_DIV);
    w_neg_a      = w_signed_div & i_a[WIDTH-1];
    w_neg_b      = w_signed_div & i_b[WIDTH-1];
    w_mag_a      = w_neg_a ? -i_a : i_a;
    w_mag_b      = w_neg_b ? -i_b : i_b;
    w_b_zero     = (i_b == '0);
    // A dummy divisor keeps the divider defined; the result is discarded anyway.
    w_div_b      = w_b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : w_mag_b;
    w_q          = w_mag_a / w_div_b;
    w_r          = w_mag_a % w_div_b;
    if (w_neg_a ^ w_neg_b) w_q = -w_q;
    if (w_neg_a)           w_r = -w_r;

    o_rhi         = '0;
    o_rlo         = '0;
    o_div_by_zero = 1'b0;
    case (i_op)
      MDU_MULT:  {o_rhi, o_rlo} = w_prod_s;
      MDU_MULTU: {o_rhi, o_rlo} = w_prod_u;
      MDU_DIV, MDU_DIVU: begin
        o_rhi         = w_r;
        o_rlo         = w_q;
        o_div_by_zero = w_b_zero;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// EX-stage multiply/divide unit owning HI/LO; fixed-latency busy window
// timed by a down-counter, result committed when the counter reaches 1.
//   state    | meaning
//   MDU_IDLE | no op in flight, busy=0, MTHI/MTLO and new ops accepted
//   MDU_RUN  | MULT/DIV in flight, busy=1, pending result held
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             cancel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  mdu_state_e       r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_hi, r_lo, w_hi_nxt, w_lo_nxt;
  logic [WIDTH-1:0] r_phi, r_plo;
  logic             r_pdbz;
  logic [WIDTH-1:0] w_rhi, w_rlo;
  logic             w_dbz;
  logic             w_accept;
  logic             w_load;

  mdu_arith #(.WIDTH(WIDTH)) u_arith (
    .i_op          (op),
    .i_a           (a),
    .i_b           (b),
    .o_rhi         (w_rhi),
    .o_rlo         (w_rlo),
    .o_div_by_zero (w_dbz)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_load      = 1'b0;
    w_accept    = start & ~cancel & (r_state == MDU_IDLE);
    case (r_state)
      MDU_IDLE: begin
        if (w_accept) begin
          case (op)
            MDU_MULT, MDU_MULTU: begin
              w_load      = 1'b1;
              w_cnt_nxt   = CW'(MULT_CYCLES);
              w_state_nxt = MDU_RUN;
            end
            MDU_DIV, MDU_DIVU: begin
              w_load      = 1'b1;
              w_cnt_nxt   = CW'(DIV_CYCLES);
              w_state_nxt = MDU_RUN;
            end
            MDU_MTHI: w_hi_nxt = a;
            MDU_MTLO: w_lo_nxt = a;
            default: ;
          endcase
        end
      end
      MDU_RUN: begin
        w_cnt_nxt = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_state_nxt = MDU_IDLE;
          if (!r_pdbz) begin
            w_hi_nxt = r_phi;
            w_lo_nxt = r_plo;
          end
        end
      end
      default: w_state_nxt = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= MDU_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_phi   <= '0;
      r_plo   <= '0;
      r_pdbz  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      if (w_load) begin
        r_phi  <= w_rhi;
        r_plo  <= w_rlo;
        r_pdbz <= w_dbz;
      end
    end
  end

  assign busy = (r_state == MDU_RUN);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: table vectors and random ops through
// a scoreboard, plus hand sequences for reset, cancel, ignored start and back-to-back.
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, cancel;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .cancel (cancel),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    int          cyc;
  } vec_t;

  typedef struct {
    logic [31:0] hi, lo;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  vec_t        tbl[12];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model; updates the bench's copy of HI/LO as an accepted op would.
  task automatic model_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          output exp_t e);
    longint          sp, sq, sr;
    longint unsigned up;
    e.hi = m_hi; e.lo = m_lo; e.cyc = 0;
    case (o)
      3'd0: begin sp = longint'($signed(x)) * longint'($signed(y)); {e.hi, e.lo} = sp; e.cyc = 5; end
      3'd1: begin up = {32'd0, x} * {32'd0, y}; {e.hi, e.lo} = up; e.cyc = 5; end
      3'd2: begin
        e.cyc = 10;
        if (y != 0) begin
          sq = longint'($signed(x)) / longint'($signed(y));
          sr = longint'($signed(x)) % longint'($signed(y));
          e.lo = sq[31:0]; e.hi = sr[31:0];
        end
      end
      3'd3: begin e.cyc = 10; if (y != 0) begin e.lo = x / y; e.hi = x % y; end end
      3'd4: e.hi = x;
      3'd5: e.lo = x;
      default: ;
    endcase
    m_hi = e.hi; m_lo = e.lo;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic c);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y; cancel = c;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0; op = 3'd6;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic pop_check(input string name, input int cyc);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_int({name, " scoreboard empty"}, 0, 1);
    end else begin
      e = sb_q.pop_front();
      check_int({name, " busy cycles"}, cyc, e.cyc);
      check32({name, " hi"}, hi, e.hi);
      check32({name, " lo"}, lo, e.lo);
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    int   cyc;
    model_op(o, x, y, e);
    sb_q.push_back(e);
    issue(o, x, y, 1'b0);
    wait_done(cyc);
    pop_check(name, cyc);
  endtask

  initial begin
    exp_t        e;
    exp_t        tmp;
    int          cyc;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    tbl[0]  = '{3'd0, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, 5};
    tbl[1]  = '{3'd1, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
    tbl[2]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    tbl[3]  = '{3'd4, 32'h00000011, 32'd0,        32'h00000011, 32'hFFFFFFFD, 0};
    tbl[4]  = '{3'd5, 32'h00000022, 32'd0,        32'h00000011, 32'h00000022, 0};
    tbl[5]  = '{3'd3, 32'd7,        32'd0,        32'h00000011, 32'h00000022, 10};
    tbl[6]  = '{3'd4, 32'h00001234, 32'd0,        32'h00001234, 32'h00000022, 0};
    tbl[7]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    tbl[8]  = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    tbl[9]  = '{3'd3, 32'hFFFFFFFF, 32'd16,       32'h0000000F, 32'h0FFFFFFF, 10};
    tbl[10] = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
    tbl[11] = '{3'd7, 32'd5,        32'd9,        32'h40000000, 32'h00000000, 0};

    reset = 1'b0; start = 1'b0; cancel = 1'b0; op = 3'd6; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check_int("reset busy", int'(busy), 0);
    check32("reset hi", hi, 32'd0);
    check32("reset lo", lo, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      model_op(tbl[i].op, tbl[i].a, tbl[i].b, tmp);
      e.hi = tbl[i].hi; e.lo = tbl[i].lo; e.cyc = tbl[i].cyc;
      sb_q.push_back(e);
      issue(tbl[i].op, tbl[i].a, tbl[i].b, 1'b0);
      wait_done(cyc);
      pop_check($sformatf("vec%0d", i), cyc);
    end

    for (int i = 0; i < 8; i++) begin
      ro = 3'($urandom_range(0, 5));
      ra = $urandom;
      rb = (i % 2 == 0) ? $urandom : 32'($urandom_range(0, 40));
      run_op($sformatf("rand%0d", i), ro, ra, rb);
    end

    // MTLO and MULT with cancel are both dropped.
    issue(3'd5, 32'hDEADBEEF, 32'd0, 1'b1);
    check32("mtlo cancel lo", lo, m_lo);
    check32("mtlo cancel hi", hi, m_hi);
    issue(3'd0, 32'd3, 32'd4, 1'b1);
    check_int("mult cancel busy", int'(busy), 0);
    @(negedge clk);
    check_int("mult cancel busy later", int'(busy), 0);

    // DIV presented on busy cycle 3 of a MULT is ignored.
    model_op(3'd0, 32'h00010000, 32'h00030000, e);
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'h00010000; b = 32'h00030000;
    @(negedge clk);
    start = 1'b0; op = 3'd6;
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      if (cyc == 3) begin start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7; end
      else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0; op = 3'd6;
    pop_check("mult w/ ignored div", cyc);

    // Back-to-back: DIV, then MULT on the first idle cycle.
    model_op(3'd2, 32'hFFFFFF9C, 32'd7, e);
    sb_q.push_back(e);
    issue(3'd2, 32'hFFFFFF9C, 32'd7, 1'b0);
    wait_done(cyc);
    pop_check("b2b div", cyc);
    model_op(3'd1, 32'h12345678, 32'h9ABCDEF0, e);
    sb_q.push_back(e);
    start = 1'b1; op = 3'd1; a = 32'h12345678; b = 32'h9ABCDEF0;
    @(negedge clk);
    start = 1'b0; op = 3'd6;
    check_int("b2b busy resumes", int'(busy), 1);
    wait_done(cyc);
    pop_check("b2b mult", cyc);

    // Reset in the middle of a MULT discards the result.
    issue(3'd0, 32'd3, 32'd5, 1'b0);
    check_int("pre-reset busy", int'(busy), 1);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_int("mid reset busy", int'(busy), 0);
    check32("mid reset hi", hi, 32'd0);
    check32("mid reset lo", lo, 32'd0);
    reset = 1'b1;
    m_hi = '0; m_lo = '0;
    repeat (8) @(negedge clk);
    check_int("post reset busy", int'(busy), 0);
    check32("post reset hi", hi, 32'd0);
    check32("post reset lo", lo, 32'd0);

    check_int("scoreboard drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
